multi_entry_res_station: RTL and testbench
==========================================

// Module: multi_entry_res_station
// PURPOSE
//   Parametrised Tomasulo reservation station with DEPTH entries, one per functional unit (ALU, MUL, DIV).
//   Sits between the CU/RegFile dispatch path and the FU state machine (pmfState/mfState).
//   Entries stay busy until their own label is broadcast on the CDB.
//   Generalised features:
//   - any depth
//   - dispatch-cycle CDB bypass into the operands
//   - oldest-ready-first issue
//   - occupancy count
//   - synchronous flush
// PARAMETERS
//   DEPTH       4      number of entries (1..2**IDX_W)
//   DATA_W      32     operand/result width
//   OP_W        2      opcode width
//   IDX_W       2      entry-index field of label
//   ID_W        2      station-ID field of label
//   STATION_ID  2'b01  this station's ID; must be nonzero
//   LABEL_W     ID_W+IDX_W (derived, 4 by default); label = {STATION_ID, entry_idx}; label 0 = "value present"
// PORTS
//   clk                 in   1        rising-edge clock
//   nRST                in   1        async active-low reset
//   WEN                 in   1        dispatch request
//   opCode              in   OP_W     dispatched op
//   dataIn1 / label1    in   DATA_W / LABEL_W  source 1 value / producer label
//   dataIn2 / label2    in   DATA_W / LABEL_W  source 2 value / producer label
//   flush               in   1        clear all entries
//   BCEN                in   1        CDB valid
//   BClabel             in   LABEL_W  CDB producer label
//   BCdata              in   DATA_W   CDB value
//   EXEable             in   1        FU can accept an op this cycle
//   OutEn               out  1        issue valid
//   opOut               out  OP_W     issued op
//   dataOut1 / dataOut2 out  DATA_W   issued operands
//   ready_labelOut      out  LABEL_W  label of issued entry
//   writeable_labelOut  out  LABEL_W  label the next dispatch will receive; 0 when full
//   isFull              out  1        all entries busy
//   count               out  IDX_W+1  busy entries
// BEHAVIOUR
//   Reset (nRST=0, async)
//   - All entries cleared; all outputs 0.
//   - Exception: writeable_labelOut = {STATION_ID,0}.
//   Entry state: busy, issued, op, V1/Q1, V2/Q2, age rank.
//   Dispatch (WEN & !isFull at edge)
//   - Writes the lowest-index free entry, whose label is the current writeable_labelOut.
//   - Sets busy=1, issued=0.
//   - WEN while isFull is ignored; no state change.
//   Snoop (each edge, BCEN=1)
//   - For every busy entry, any Qn==BClabel!=0 takes Vn<=BCdata, Qn<=0.
//   - Bypass: at a dispatch with BCEN & labelN==BClabel, the entry stores BCdata and Qn=0 directly.
//   Issue (combinational)
//   - An entry is ready when busy & !issued & Q1==0 & Q2==0.
//   - OutEn = EXEable & any ready. Among ready entries, the oldest by dispatch order is selected.
//   - opOut/dataOut*/ready_labelOut reflect that entry while OutEn=1, else all 0.
//   - At the edge with OutEn=1 the entry sets issued=1; it is never reissued.
//   - An entry dispatched or woken this cycle is first eligible next cycle: no combinational path from WEN/BC* to OutEn.
//   Free
//   - At an edge with BCEN & BClabel=={STATION_ID,i} & busy[i], entry i is cleared.
//   - This happens whether or not the entry was issued.
//   Simultaneous events
//   - Free and dispatch in the same cycle: both happen. The dispatch uses a free entry from the start of the cycle, so isFull/writeable_labelOut do not see the freed slot until next cycle.
//   - flush (sync) wins over dispatch, snoop and issue-marking: all entries cleared next cycle.
//   - BClabel with a foreign STATION_ID only wakes operands; it never frees.
//   count/isFull are registered from next-state; count==DEPTH <=> isFull.
// TESTING
//   - Reset, then dispatch 4 ops with labels 0 and EXEable=0: writeable_labelOut goes 4'h4,5,6,7,then 0; isFull=1; count=4.
//   - Dispatch with label1=4'h9, BCEN=1, BClabel=4'h9, BCdata=32'hDEAD in the same cycle, then EXEable=1: next cycle OutEn=1, dataOut1=32'hDEAD.
//   - Dispatch A (label2=4'hA), then B (ready), then A's BC: B issues first; A issues the cycle after the wakeup, A before any later-dispatched ready op.
//   - Full station; BCEN with BClabel=4'h5 and WEN the same cycle: WEN ignored; next cycle isFull=0, writeable_labelOut=4'h5, count=3.
//   - flush with WEN=1 and 3 busy entries: next cycle count=0, OutEn=0, the dispatched op absent.
//   - Assert nRST low mid-issue (OutEn=1): all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multi_entry_res_station.sv
// Tomasulo reservation station: DEPTH entries, CDB snoop/bypass, oldest-ready-first issue.
// Entries stay busy until their own label appears on the CDB.
module multi_entry_res_station #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned OP_W       = 2,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned ID_W       = 2,
  parameter logic [ID_W-1:0] STATION_ID = 2'b01,
  localparam int unsigned LABEL_W   = ID_W + IDX_W
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               WEN,
  input  logic [OP_W-1:0]    opCode,
  input  logic [DATA_W-1:0]  dataIn1,
  input  logic [LABEL_W-1:0] label1,
  input  logic [DATA_W-1:0]  dataIn2,
  input  logic [LABEL_W-1:0] label2,
  input  logic               flush,
  input  logic               BCEN,
  input  logic [LABEL_W-1:0] BClabel,
  input  logic [DATA_W-1:0]  BCdata,
  input  logic               EXEable,
  output logic               OutEn,
  output logic [OP_W-1:0]    opOut,
  output logic [DATA_W-1:0]  dataOut1,
  output logic [DATA_W-1:0]  dataOut2,
  output logic [LABEL_W-1:0] ready_labelOut,
  output logic [LABEL_W-1:0] writeable_labelOut,
  output logic               isFull,
  output logic [IDX_W:0]     count
);

  logic [DEPTH-1:0]   busy_q, busy_d, issued_q, issued_d;
  logic [OP_W-1:0]    op_q [DEPTH];
  logic [OP_W-1:0]    op_d [DEPTH];
  logic [DATA_W-1:0]  v1_q [DEPTH];
  logic [DATA_W-1:0]  v1_d [DEPTH];
  logic [DATA_W-1:0]  v2_q [DEPTH];
  logic [DATA_W-1:0]  v2_d [DEPTH];
  logic [LABEL_W-1:0] q1_q [DEPTH];
  logic [LABEL_W-1:0] q1_d [DEPTH];
  logic [LABEL_W-1:0] q2_q [DEPTH];
  logic [LABEL_W-1:0] q2_d [DEPTH];
  // older_q[j][i] set means entry j was dispatched before entry i
  logic [DEPTH-1:0]   older_q [DEPTH];
  logic [DEPTH-1:0]   older_d [DEPTH];
  logic [IDX_W:0]     count_q, count_d;
  logic               full_q;

  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [DEPTH-1:0]   ready, sel_oh;
  logic               blocked;
  logic               do_disp;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign writeable_labelOut = free_found ? {STATION_ID, free_idx} : '0;
  assign do_disp            = WEN && free_found;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && !issued_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
    end
  end

  // An entry is selected when no other ready entry is older than it.
  always_comb begin
    blocked = 1'b0;
    sel_oh  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older_q[j][i]) blocked = 1'b1;
      end
      sel_oh[i] = ready[i] && !blocked;
    end
  end

  assign OutEn = EXEable && (|ready);

  always_comb begin
    opOut          = '0;
    dataOut1       = '0;
    dataOut2       = '0;
    ready_labelOut = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (OutEn && sel_oh[i]) begin
        opOut          = op_q[i];
        dataOut1       = v1_q[i];
        dataOut2       = v2_q[i];
        ready_labelOut = {STATION_ID, IDX_W'(i)};
      end
    end
  end

  always_comb begin
    busy_d   = busy_q;
    issued_d = issued_q;
    op_d     = op_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    q1_d     = q1_q;
    q2_d     = q2_q;
    older_d  = older_q;
    if (flush) begin
      busy_d   = '0;
      issued_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (BCEN && busy_q[i] && (BClabel != '0)) begin
          if (q1_q[i] == BClabel) begin
            v1_d[i] = BCdata;
            q1_d[i] = '0;
          end
          if (q2_q[i] == BClabel) begin
            v2_d[i] = BCdata;
            q2_d[i] = '0;
          end
        end
        if (OutEn && sel_oh[i]) issued_d[i] = 1'b1;
        if (BCEN && busy_q[i] && (BClabel == {STATION_ID, IDX_W'(i)})) begin
          busy_d[i]   = 1'b0;
          issued_d[i] = 1'b0;
        end
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (do_disp && (free_idx == IDX_W'(k))) begin
          busy_d[k]   = 1'b1;
          issued_d[k] = 1'b0;
          op_d[k]     = opCode;
          if (BCEN && (label1 != '0) && (label1 == BClabel)) begin
            v1_d[k] = BCdata;
            q1_d[k] = '0;
          end else begin
            v1_d[k] = dataIn1;
            q1_d[k] = label1;
          end
          if (BCEN && (label2 != '0) && (label2 == BClabel)) begin
            v2_d[k] = BCdata;
            q2_d[k] = '0;
          end else begin
            v2_d[k] = dataIn2;
            q2_d[k] = label2;
          end
          for (int j = 0; j < DEPTH; j++) older_d[j][k] = busy_q[j];
          older_d[k] = '0;
        end
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d = count_d + (IDX_W+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy_q   <= '0;
      issued_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        v1_q[i]    <= '0;
        v2_q[i]    <= '0;
        q1_q[i]    <= '0;
        q2_q[i]    <= '0;
        older_q[i] <= '0;
      end
    end else begin
      busy_q   <= busy_d;
      issued_q <= issued_d;
      count_q  <= count_d;
      full_q   <= (count_d == (IDX_W+1)'(DEPTH));
      op_q     <= op_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      q1_q     <= q1_d;
      q2_q     <= q2_d;
      older_q  <= older_d;
    end
  end

  assign count  = count_q;
  assign isFull = full_q;

endmodule

// File: tb/tb_multi_entry_res_station.sv
// Scoreboard bench for multi_entry_res_station: expected issues are queued at dispatch
// and compared whenever the station presents OutEn.
module tb_multi_entry_res_station;

  logic        clk = 1'b0;
  logic        nRST;
  logic        WEN, flush, BCEN, EXEable;
  logic [1:0]  opCode;
  logic [31:0] dataIn1, dataIn2, BCdata;
  logic [3:0]  label1, label2, BClabel;
  logic        OutEn, isFull;
  logic [1:0]  opOut;
  logic [31:0] dataOut1, dataOut2;
  logic [3:0]  ready_labelOut, writeable_labelOut;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  lbl;
  } issue_t;
  issue_t sb[$];

  multi_entry_res_station dut (
    .clk               (clk),
    .nRST              (nRST),
    .WEN               (WEN),
    .opCode            (opCode),
    .dataIn1           (dataIn1),
    .label1            (label1),
    .dataIn2           (dataIn2),
    .label2            (label2),
    .flush             (flush),
    .BCEN              (BCEN),
    .BClabel           (BClabel),
    .BCdata            (BCdata),
    .EXEable           (EXEable),
    .OutEn             (OutEn),
    .opOut             (opOut),
    .dataOut1          (dataOut1),
    .dataOut2          (dataOut2),
    .ready_labelOut    (ready_labelOut),
    .writeable_labelOut(writeable_labelOut),
    .isFull            (isFull),
    .count             (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue monitor; inputs change #1 after posedge so negedge sees the issuing value.
  always @(negedge clk) begin
    if (nRST && OutEn) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", {60'd0, ready_labelOut}, 64'd0);
      end else begin
        issue_t e;
        e = sb.pop_front();
        check("issue_op", {62'd0, opOut}, {62'd0, e.op});
        check("issue_d1", {32'd0, dataOut1}, {32'd0, e.d1});
        check("issue_d2", {32'd0, dataOut2}, {32'd0, e.d2});
        check("issue_lbl", {60'd0, ready_labelOut}, {60'd0, e.lbl});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [1:0] op, input logic [31:0] d1, input logic [3:0] l1,
                      input logic [31:0] d2, input logic [3:0] l2);
    WEN = 1'b1; opCode = op; dataIn1 = d1; label1 = l1; dataIn2 = d2; label2 = l2;
    cyc();
    WEN = 1'b0;
  endtask

  task automatic bc(input logic [3:0] lbl, input logic [31:0] d);
    BCEN = 1'b1; BClabel = lbl; BCdata = d;
    cyc();
    BCEN = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    issue_t e;
    nRST = 1'b0; WEN = 0; flush = 0; BCEN = 0; EXEable = 0;
    opCode = 0; dataIn1 = 0; dataIn2 = 0; BCdata = 0; label1 = 0; label2 = 0; BClabel = 0;
    #12;
    check("rst_outen", {63'd0, OutEn}, 64'd0);
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_full", {63'd0, isFull}, 64'd0);
    check("rst_wlabel", {60'd0, writeable_labelOut}, 64'h4);
    @(negedge clk);
    nRST = 1'b1;
    cyc();

    // Fill with ready ops while the FU is busy.
    for (int i = 0; i < 4; i++) begin
      disp(2'(i), 32'h100 + i, 4'h0, 32'h200 + i, 4'h0);
      check("fill_wlabel", {60'd0, writeable_labelOut}, (i == 3) ? 64'h0 : 64'(5 + i));
    end
    check("fill_full", {63'd0, isFull}, 64'd1);
    check("fill_count", {61'd0, count}, 64'd4);
    disp(2'd3, 32'hBAD, 4'h0, 32'hBAD, 4'h0);
    check("full_ignore_count", {61'd0, count}, 64'd4);

    for (int i = 0; i < 4; i++) begin
      e.op = 2'(i); e.d1 = 32'h100 + i; e.d2 = 32'h200 + i; e.lbl = 4'(4 + i);
      sb.push_back(e);
    end
    EXEable = 1'b1;
    repeat (4) cyc();
    EXEable = 1'b0;
    check("drain1", 64'(sb.size()), 64'd0);
    check("issued_stay_busy", {61'd0, count}, 64'd4);

    // Free label 5 while a dispatch is attempted on the full station.
    BCEN = 1'b1; BClabel = 4'h5; BCdata = 32'h55;
    disp(2'd2, 32'hBAD, 4'h0, 32'hBAD, 4'h0);
    BCEN = 1'b0;
    check("free5_full", {63'd0, isFull}, 64'd0);
    check("free5_wlabel", {60'd0, writeable_labelOut}, 64'h5);
    check("free5_count", {61'd0, count}, 64'd3);
    bc(4'h4, 32'h0);
    bc(4'h6, 32'h0);
    bc(4'h7, 32'h0);
    check("empty_count", {61'd0, count}, 64'd0);

    // Dispatch-cycle bypass from a foreign producer.
    e.op = 2'd1; e.d1 = 32'hDEAD; e.d2 = 32'h77; e.lbl = 4'h4;
    sb.push_back(e);
    EXEable = 1'b1; BCEN = 1'b1; BClabel = 4'h9; BCdata = 32'hDEAD;
    WEN = 1'b1; opCode = 2'd1; dataIn1 = 32'h0; label1 = 4'h9; dataIn2 = 32'h77; label2 = 4'h0;
    #1;
    check("bypass_no_comb", {63'd0, OutEn}, 64'd0);
    cyc();
    WEN = 1'b0; BCEN = 1'b0;
    check("bypass_outen", {63'd0, OutEn}, 64'd1);
    check("bypass_d1", {32'd0, dataOut1}, 64'hDEAD);
    cyc();
    EXEable = 1'b0;
    check("bypass_once", {63'd0, OutEn}, 64'd0);
    bc(4'h4, 32'h0);
    check("drain2", 64'(sb.size()), 64'd0);

    // Oldest-ready-first: A waits on 4'hA, B ready, C dispatched with A's wakeup.
    disp(2'd0, 32'hA1, 4'h0, 32'h0, 4'hA);
    disp(2'd1, 32'hB1, 4'h0, 32'hB2, 4'h0);
    e.op = 2'd1; e.d1 = 32'hB1; e.d2 = 32'hB2;   e.lbl = 4'h5; sb.push_back(e);
    e.op = 2'd0; e.d1 = 32'hA1; e.d2 = 32'h1234; e.lbl = 4'h4; sb.push_back(e);
    e.op = 2'd2; e.d1 = 32'hC1; e.d2 = 32'hC2;   e.lbl = 4'h6; sb.push_back(e);
    EXEable = 1'b1; BCEN = 1'b1; BClabel = 4'hA; BCdata = 32'h1234;
    disp(2'd2, 32'hC1, 4'h0, 32'hC2, 4'h0);
    BCEN = 1'b0;
    cyc();
    cyc();
    EXEable = 1'b0;
    check("drain3", 64'(sb.size()), 64'd0);
    check("order_count", {61'd0, count}, 64'd3);
    bc(4'h4, 32'h0);
    bc(4'h5, 32'h0);
    bc(4'h6, 32'h0);
    check("order_freed", {61'd0, count}, 64'd0);

    // Flush beats a same-cycle dispatch.
    for (int i = 0; i < 3; i++) disp(2'(i), 32'h300 + i, 4'h0, 32'h0, 4'h0);
    check("pre_flush_count", {61'd0, count}, 64'd3);
    flush = 1'b1;
    disp(2'd3, 32'h3FF, 4'h0, 32'h0, 4'h0);
    flush = 1'b0;
    EXEable = 1'b1;
    #1;
    check("flush_count", {61'd0, count}, 64'd0);
    check("flush_outen", {63'd0, OutEn}, 64'd0);
    check("flush_wlabel", {60'd0, writeable_labelOut}, 64'h4);
    cyc();
    EXEable = 1'b0;
    check("flush_no_issue", {63'd0, OutEn}, 64'd0);

    // Asynchronous reset while an issue is being presented.
    disp(2'd3, 32'h400, 4'h0, 32'h401, 4'h0);
    disp(2'd2, 32'h410, 4'h0, 32'h411, 4'h0);
    e.op = 2'd3; e.d1 = 32'h400; e.d2 = 32'h401; e.lbl = 4'h4; sb.push_back(e);
    EXEable = 1'b1;
    @(negedge clk);
    #1;
    check("pre_rst_outen", {63'd0, OutEn}, 64'd1);
    nRST = 1'b0;
    #1;
    check("arst_outen", {63'd0, OutEn}, 64'd0);
    check("arst_op", {62'd0, opOut}, 64'd0);
    check("arst_d1", {32'd0, dataOut1}, 64'd0);
    check("arst_d2", {32'd0, dataOut2}, 64'd0);
    check("arst_rlabel", {60'd0, ready_labelOut}, 64'd0);
    check("arst_count", {61'd0, count}, 64'd0);
    check("arst_full", {63'd0, isFull}, 64'd0);
    check("arst_wlabel", {60'd0, writeable_labelOut}, 64'h4);
    EXEable = 1'b0;
    cyc();
    nRST = 1'b1;
    cyc();
    check("drain_final", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
